sprite_frame_ctrl: RTL

Frame-synchronous controller for the cursor overlay stage. It decides which cursor sprite is drawn: 0 is the mouse pointer, 1 is the keeper gloves. It changes that choice only at the start of vertical blanking and blanks the sprite for a programmable number of frames after each switch. It also provides tear-free, once-per-frame latched cursor coordinates to both sprite drawers. It sits between the game FSM and mouse position source on one side and the cursor overlay selector/drawers on the other.

---
 rtl/sprite_frame_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sprite_frame_ctrl.sv
// rtl/sprite_frame_ctrl.sv - frame-synchronous cursor sprite select, hide and position latch (optional clamp: SPRITE_CLAMP_EN)
module sprite_frame_ctrl #(
  parameter int HOLD_FRAMES = 2,
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        keeper_req,
  input  logic        vblnk,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        sprite_sel,
  output logic        sprite_en,
  output logic [11:0] xpos_lat,
  output logic [11:0] ypos_lat,
  output logic [15:0] frame_cnt,
  output logic        switch_busy
);

  typedef enum logic [1:0] {
    ST_SHOW    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HIDE    = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES);

  // Reject parameter values the 4-bit hold counter and 12-bit clamp cannot represent.
  if (HOLD_FRAMES < 0 || HOLD_FRAMES > 15) begin : g_bad_hold
    $error("HOLD_FRAMES must be 0..15");
  end
  if (H_ACTIVE < 1 || H_ACTIVE > 4096) begin : g_bad_h
    $error("H_ACTIVE must be 1..4096");
  end
  if (V_ACTIVE < 1 || V_ACTIVE > 4096) begin : g_bad_v
    $error("V_ACTIVE must be 1..4096");
  end

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  hold_q;
  logic [3:0]  hold_d;
  logic        sel_d;
  logic        en_d;
  logic        busy_d;
  logic        vblnk_d;
  logic        tick;
  logic [11:0] x_next;
  logic [11:0] y_next;

  // A tick is the first cycle of vertical blank; vblnk_d resets high so reset release never ticks.
  assign tick = vblnk & ~vblnk_d;

`ifdef SPRITE_CLAMP_EN
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1);
  assign x_next = (xpos > X_MAX) ? X_MAX : xpos;
  assign y_next = (ypos > Y_MAX) ? Y_MAX : ypos;
`else
  assign x_next = xpos;
  assign y_next = ypos;
`endif

  // Delayed vblnk for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vblnk_d <= 1'b1;
    end else begin
      vblnk_d <= vblnk;
    end
  end

  // Once-per-frame position latch and frame counter; the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xpos_lat  <= 12'd0;
      ypos_lat  <= 12'd0;
      frame_cnt <= 16'd0;
    end else if (tick) begin
      xpos_lat  <= x_next;
      ypos_lat  <= y_next;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // FSM state plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SHOW;
      hold_q      <= 4'd0;
      sprite_sel  <= 1'b0;
      sprite_en   <= 1'b1;
      switch_busy <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sprite_sel  <= sel_d;
      sprite_en   <= en_d;
      switch_busy <= busy_d;
    end
  end

  // Next-state logic: a request waits in PENDING for the frame tick, then HIDE counts frames out.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sprite_sel;
    case (state_q)
      ST_SHOW: begin
        if (keeper_req != sprite_sel) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (tick && (keeper_req != sprite_sel)) begin
          sel_d   = keeper_req;
          hold_d  = HOLD_INIT;
          state_d = (HOLD_INIT != 4'd0) ? ST_HIDE : ST_SHOW;
        end else if (keeper_req == sprite_sel) begin
          state_d = ST_SHOW;
        end
      end
      ST_HIDE: begin
        if (tick) begin
          if (hold_q == 4'd1) begin
            state_d = ST_SHOW;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_SHOW;
      end
    endcase
    en_d   = (state_d != ST_HIDE);
    busy_d = (state_d != ST_SHOW);
  end

endmodule
